// File: rtl/bp_txn_arbiter.sv
// Transaction-aware two-requester BytePipe arbiter: grants the register target to A or B for a whole read/write.
// Optional response timeout enabled by defining BP_TXN_ARBITER_TIMEOUT_EN.
module bp_txn_arbiter #(
   parameter int unsigned FIXED_PRIORITY = 0,
   parameter int unsigned TIMEOUT        = 255
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_cg,
   input  logic [7:0] i_a_data,
   input  logic       i_a_valid,
   output logic       o_a_ready,
   input  logic [7:0] i_b_data,
   input  logic       i_b_valid,
   output logic       o_b_ready,
   output logic [7:0] o_a_data,
   output logic       o_a_valid,
   input  logic       i_a_ready,
   output logic [7:0] o_b_data,
   output logic       o_b_valid,
   input  logic       i_b_ready,
   output logic [7:0] o_t_data,
   output logic       o_t_valid,
   input  logic       i_t_ready,
   input  logic [7:0] i_t_data,
   input  logic       i_t_valid,
   output logic       o_t_ready,
   output logic [1:0] o_grant,
   output logic       o_timeout
);

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("bp_txn_arbiter: TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_CMD,
      S_DATA,
      S_RESP
   } state_t;

   state_t state_q;
   logic   grant_q;
   logic   last_q;

   logic [7:0] g_data;
   logic       g_valid;
   logic       g_rsp_ready;
   logic       fwd;
   logic       rsp_phase;
   logic       byte_acc;
   logic       rsp_done;
   logic       rsp_valid;
   logic       timeout_hit;
   logic       win_b;

   always_comb begin
      g_data      = grant_q ? i_b_data  : i_a_data;
      g_valid     = grant_q ? i_b_valid : i_a_valid;
      g_rsp_ready = grant_q ? i_b_ready : i_a_ready;
      fwd         = (state_q == S_CMD) || (state_q == S_DATA);
      rsp_phase   = (state_q == S_RESP);
      byte_acc    = fwd && g_valid && i_t_ready;
      rsp_done    = rsp_phase && i_t_valid && g_rsp_ready;
      // Round-robin: on a tie the requester that did not win last time goes next.
      win_b       = i_b_valid && (!i_a_valid || ((FIXED_PRIORITY == 0) && !last_q));
   end

`ifdef BP_TXN_ARBITER_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] to_cnt_q;

   assign timeout_hit = rsp_phase && i_t_valid && !g_rsp_ready && (to_cnt_q == CW'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      rsp_valid = rsp_phase && i_t_valid && !timeout_hit;
      o_t_data  = fwd ? g_data : '0;
      o_t_valid = fwd && g_valid;
      o_t_ready = fwd || (rsp_phase && (g_rsp_ready || timeout_hit));
      o_a_ready = fwd && !grant_q && i_t_ready;
      o_b_ready = fwd &&  grant_q && i_t_ready;
      o_a_data  = i_t_data;
      o_b_data  = i_t_data;
      o_a_valid = rsp_valid && !grant_q;
      o_b_valid = rsp_valid &&  grant_q;
      o_timeout = timeout_hit;
      o_grant   = '0;
      if (state_q != S_IDLE) begin
         o_grant = grant_q ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
      end else if (i_cg) begin
         case (state_q)
            S_IDLE: begin
               if (i_a_valid || i_b_valid) begin
                  grant_q <= win_b;
                  last_q  <= win_b;
                  state_q <= S_CMD;
               end
            end
            S_CMD: begin
               if (byte_acc) begin
                  state_q <= g_data[7] ? S_DATA : S_RESP;
               end
            end
            S_DATA: begin
               if (byte_acc) begin
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_done || timeout_hit) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef BP_TXN_ARBITER_TIMEOUT_EN
   // Cleared while forwarding so it starts from zero on every entry to RESP.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         to_cnt_q <= '0;
      end else if (i_cg) begin
         if (fwd) begin
            to_cnt_q <= '0;
         end else if (rsp_phase && i_t_valid && !g_rsp_ready && !timeout_hit) begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bp_txn_arbiter.sv
// Scoreboard bench for bp_txn_arbiter: directed transactions, queue-based expected target bytes, responses and grants.
`timescale 1ns/1ps
module tb_bp_txn_arbiter;

`ifdef BP_TXN_ARBITER_TIMEOUT_EN
   localparam int unsigned TB_TIMEOUT = 4;
`else
   localparam int unsigned TB_TIMEOUT = 255;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cg = 1'b1;
   logic [7:0] a_data = '0, b_data = '0;
   logic [1:0] rq_valid = '0;
   logic [1:0] rs_ready = 2'b11;
   logic [1:0] o_rdy, o_vld;
   logic [7:0] od_a, od_b;
   logic [7:0] t_data_o;
   logic       t_valid_o, t_ready_o;
   logic       t_rdy = 1'b1;
   logic       t_valid = 1'b0;
   logic [7:0] t_data = '0;
   logic [1:0] grant;
   logic       timeout;

   // fixed-priority instance with an always-responding target
   logic [1:0] fp_valid = '0;
   logic [1:0] fp_rdy, fp_vld, fp_grant;
   logic [7:0] fp_od_a, fp_od_b, fp_t_data;
   logic       fp_t_valid, fp_t_ready, fp_timeout;

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] exp_t[$];
   logic [7:0] exp_ra[$];
   logic [7:0] exp_rb[$];
   logic [1:0] exp_g[$];
   logic [7:0] tgt_rsp[$];

   always #5 clk = ~clk;

   bp_txn_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT(TB_TIMEOUT)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg),
      .i_a_data(a_data), .i_a_valid(rq_valid[0]), .o_a_ready(o_rdy[0]),
      .i_b_data(b_data), .i_b_valid(rq_valid[1]), .o_b_ready(o_rdy[1]),
      .o_a_data(od_a), .o_a_valid(o_vld[0]), .i_a_ready(rs_ready[0]),
      .o_b_data(od_b), .o_b_valid(o_vld[1]), .i_b_ready(rs_ready[1]),
      .o_t_data(t_data_o), .o_t_valid(t_valid_o), .i_t_ready(t_rdy),
      .i_t_data(t_data), .i_t_valid(t_valid), .o_t_ready(t_ready_o),
      .o_grant(grant), .o_timeout(timeout)
   );

   bp_txn_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT(TB_TIMEOUT)) dut_fp (
      .i_clk(clk), .i_rst_n(rst_n), .i_cg(1'b1),
      .i_a_data(8'h01), .i_a_valid(fp_valid[0]), .o_a_ready(fp_rdy[0]),
      .i_b_data(8'h01), .i_b_valid(fp_valid[1]), .o_b_ready(fp_rdy[1]),
      .o_a_data(fp_od_a), .o_a_valid(fp_vld[0]), .i_a_ready(1'b1),
      .o_b_data(fp_od_b), .o_b_valid(fp_vld[1]), .i_b_ready(1'b1),
      .o_t_data(fp_t_data), .o_t_valid(fp_t_valid), .i_t_ready(1'b1),
      .i_t_data(8'h3C), .i_t_valid(1'b1), .o_t_ready(fp_t_ready),
      .o_grant(fp_grant), .o_timeout(fp_timeout)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds valid until the byte is accepted, as BytePipe requires.
   task automatic send_byte(input int s, input logic [7:0] b);
      bit hs = 1'b0;
      int n = 0;
      if (s == 0) a_data = b; else b_data = b;
      rq_valid[s] = 1'b1;
      while (!hs && n < 60) begin
         @(negedge clk);
         hs = o_rdy[s];
         tick();
         n++;
      end
      rq_valid[s] = 1'b0;
      if (!hs) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: requester %0d byte 0x%0h got no ready, required accept", s, b);
      end
   endtask

   // Target model: response presented after the last byte of a transaction.
   bit       pend_w = 1'b0;
   bit       rst_seen = 1'b0;
   always @(negedge rst_n) begin
      t_valid  = 1'b0;
      pend_w   = 1'b0;
      rst_seen = 1'b1;
   end

   initial begin
      bit acc, racc;
      logic [7:0] bt;
      forever begin
         @(negedge clk);
         acc  = t_valid_o && t_rdy;
         bt   = t_data_o;
         racc = t_valid && t_ready_o;
         tick();
         if (rst_seen || !rst_n) begin
            rst_seen = 1'b0;
         end else begin
            if (racc) t_valid = 1'b0;
            if (acc) begin
               if (!pend_w && bt[7]) begin
                  pend_w = 1'b1;
               end else begin
                  pend_w  = 1'b0;
                  t_valid = 1'b1;
                  t_data  = (tgt_rsp.size() != 0) ? tgt_rsp.pop_front() : 8'hEE;
               end
            end
         end
      end
   end

   // Monitor: pops expected values whenever the DUT presents a handshake or new grant.
   initial begin
      logic [1:0] prev = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (t_valid_o && t_rdy) begin
               if (exp_t.size() == 0) chk("t_byte_unexpected", {24'h0, t_data_o}, 32'h100);
               else chk("t_byte", {24'h0, t_data_o}, {24'h0, exp_t.pop_front()});
            end
            if (o_vld[0] && rs_ready[0]) begin
               if (exp_ra.size() == 0) chk("a_rsp_unexpected", {24'h0, od_a}, 32'h100);
               else chk("a_rsp", {24'h0, od_a}, {24'h0, exp_ra.pop_front()});
            end
            if (o_vld[1] && rs_ready[1]) begin
               if (exp_rb.size() == 0) chk("b_rsp_unexpected", {24'h0, od_b}, 32'h100);
               else chk("b_rsp", {24'h0, od_b}, {24'h0, exp_rb.pop_front()});
            end
            if (grant != 2'b00 && prev == 2'b00) begin
               if (exp_g.size() == 0) chk("grant_unexpected", {30'h0, grant}, 32'h0);
               else chk("grant", {30'h0, grant}, {30'h0, exp_g.pop_front()});
            end
            if (grant == 2'b01) chk("b_held_off", {30'h0, o_vld[1], o_rdy[1]}, 32'h0);
            if (grant == 2'b10) chk("a_held_off", {30'h0, o_vld[0], o_rdy[0]}, 32'h0);
            if (grant == 2'b00)
               chk("idle_quiet", {27'h0, o_vld, o_rdy, t_ready_o}, 32'h0);
            prev = grant;
         end else begin
            prev = '0;
         end
      end
   end

   task automatic run_fp();
      logic [1:0] fexp[$];
      logic [1:0] prev = '0;
      int na = 0, nb = 0, n = 0;
      fexp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
      fp_valid = 2'b11;
      while ((fexp.size() != 0 || fp_valid != 2'b00) && n < 200) begin
         @(negedge clk);
         if (fp_grant != 2'b00 && prev == 2'b00) begin
            if (fexp.size() == 0) chk("fp_grant_unexpected", {30'h0, fp_grant}, 32'h0);
            else chk("fp_grant", {30'h0, fp_grant}, {30'h0, fexp.pop_front()});
         end
         prev = fp_grant;
         if (fp_rdy[0] && fp_valid[0]) na++;
         if (fp_rdy[1] && fp_valid[1]) nb++;
         tick();
         if (na == 4) fp_valid[0] = 1'b0;
         if (nb == 1) fp_valid[1] = 1'b0;
         n++;
      end
      fp_valid = '0;
      chk("fp_done", {31'h0, n < 200}, 32'h1);
   endtask

   initial begin
      int n;
      // reset state, with requests pending
      rq_valid = 2'b11;
      #2;
      chk("rst_grant", {30'h0, grant}, 32'h0);
      chk("rst_t", {22'h0, t_valid_o, t_ready_o, t_data_o}, 32'h0);
      chk("rst_req_side", {26'h0, o_rdy, o_vld, timeout, 1'b0}, 32'h0);
      rq_valid = 2'b00;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // read from A: 0x07 -> 0x03, one bubble, 3-cycle transaction
      exp_g.push_back(2'b01); exp_t.push_back(8'h07); exp_ra.push_back(8'h03); tgt_rsp.push_back(8'h03);
      a_data = 8'h07; rq_valid[0] = 1'b1;
      @(negedge clk);
      chk("rd_bubble", {30'h0, grant, 1'b0, o_rdy[0]} >> 1, 32'h0);
      tick();
      @(negedge clk);
      chk("rd_cmd", {22'h0, grant, t_data_o}, {22'h0, 2'b01, 8'h07});
      chk("rd_a_ready", {31'h0, o_rdy[0]}, 32'h1);
      tick();
      rq_valid[0] = 1'b0;
      @(negedge clk);
      chk("rd_resp", {23'h0, o_vld[0], od_a}, {23'h0, 1'b1, 8'h03});
      tick();
      @(negedge clk);
      chk("rd_idle", {30'h0, grant}, 32'h0);
      tick();

      // write from B: 0x88, 0x05 with target stalled 3 cycles in DATA
      exp_g.push_back(2'b10); exp_t.push_back(8'h88); exp_t.push_back(8'h05);
      exp_rb.push_back(8'h5A); tgt_rsp.push_back(8'h5A);
      b_data = 8'h88; rq_valid[1] = 1'b1;
      tick();
      @(negedge clk);
      chk("wr_cmd_ready", {31'h0, o_rdy[1]}, 32'h1);
      tick();
      b_data = 8'h05; t_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wr_stall_ready", {30'h0, o_rdy[1], t_valid_o}, 32'h1);
         tick();
      end
      t_rdy = 1'b1;
      @(negedge clk);
      chk("wr_data_ready", {31'h0, o_rdy[1]}, 32'h1);
      tick();
      rq_valid[1] = 1'b0;
      @(negedge clk);
      chk("wr_resp", {23'h0, o_vld[1], od_b}, {23'h0, 1'b1, 8'h5A});
      tick();
      @(negedge clk);
      chk("wr_idle", {30'h0, grant}, 32'h0);
      tick();

      // continuous A/B reads under round-robin
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_t = '{8'h11, 8'h21, 8'h12, 8'h22};
      tgt_rsp = '{8'hA1, 8'hB1, 8'hA2, 8'hB2};
      exp_ra = '{8'hA1, 8'hA2};
      exp_rb = '{8'hB1, 8'hB2};
      fork
         begin send_byte(0, 8'h11); send_byte(0, 8'h12); end
         begin send_byte(1, 8'h21); send_byte(1, 8'h22); end
      join
      repeat (4) tick();

      run_fp();

      // clock gate low freezes arbitration
      a_data = 8'h02; rq_valid[0] = 1'b1; cg = 1'b0;
      exp_g.push_back(2'b01); exp_t.push_back(8'h02); exp_ra.push_back(8'h62); tgt_rsp.push_back(8'h62);
      repeat (2) begin
         @(negedge clk);
         chk("cg_frozen", {30'h0, grant}, 32'h0);
         tick();
      end
      cg = 1'b1;
      send_byte(0, 8'h02);
      repeat (3) tick();

      // async reset while in DATA
      exp_g.push_back(2'b01); exp_t.push_back(8'h90);
      a_data = 8'h90; rq_valid[0] = 1'b1;
      tick(); tick();
      a_data = 8'h06;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst", {21'h0, grant, o_rdy, t_valid_o, t_data_o}, 32'h0);
      rq_valid[0] = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      exp_g.push_back(2'b01); exp_g.push_back(2'b10);
      exp_t.push_back(8'h31); exp_t.push_back(8'h41);
      tgt_rsp.push_back(8'hC1); tgt_rsp.push_back(8'hC2);
      exp_ra.push_back(8'hC1); exp_rb.push_back(8'hC2);
      fork
         send_byte(0, 8'h31);
         send_byte(1, 8'h41);
      join
      repeat (4) tick();

`ifdef BP_TXN_ARBITER_TIMEOUT_EN
      // A withholds response ready: response dropped on the 4th stalled cycle
      exp_g.push_back(2'b01); exp_t.push_back(8'h55); tgt_rsp.push_back(8'h77);
      rs_ready[0] = 1'b0;
      send_byte(0, 8'h55);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("to_pulse", {31'h0, timeout}, {31'h0, k == 4});
         if (k == 4) chk("to_drain", {30'h0, t_ready_o, o_vld[0]}, 32'h2);
         tick();
      end
      @(negedge clk);
      chk("to_idle", {29'h0, grant, t_valid}, 32'h0);
      rs_ready[0] = 1'b1;
      tick();
`endif

      n = 0;
      while ((exp_t.size() + exp_ra.size() + exp_rb.size() + exp_g.size()) != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("q_t_empty", exp_t.size(), 0);
      chk("q_ra_empty", exp_ra.size(), 0);
      chk("q_rb_empty", exp_rb.size(), 0);
      chk("q_g_empty", exp_g.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
